// File: rtl/btn_debounce_pulse.sv
// Push-button conditioning: two-flop synchroniser, per-button stability
// counter, debounced level output and a one-hot press pulse. A change on the
// synchronised input is accepted only after DB_COUNT consecutive cycles that
// disagree with the current level. When several buttons are accepted as
// pressed on the same cycle, only the lowest-index one pulses. The others
// lose their pulse.
module btn_debounce_pulse #(
    parameter int unsigned NB_BTN   = 3,
    parameter int unsigned NB_CNT   = 20,
    parameter int unsigned DB_COUNT = 1000000
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_pulse
);

    // Final counter value before an accept; the counter never goes past it.
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DB_COUNT - 1);

    logic [NB_BTN-1:0] sync1_q;
    logic [NB_BTN-1:0] sync2_q;
    logic [NB_CNT-1:0] cnt_q [NB_BTN];
    logic [NB_CNT-1:0] cnt_d [NB_BTN];
    logic [NB_BTN-1:0] level_q;
    logic [NB_BTN-1:0] level_d;
    logic [NB_BTN-1:0] pulse_q;
    logic [NB_BTN-1:0] pulse_d;
    logic [NB_BTN-1:0] accept;
    logic [NB_BTN-1:0] rise;

    // Bring the raw asynchronous buttons into the clock domain.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreements between the synchronised input and the level.
    // Accept the change once the count reaches its final value.
    always_comb begin
        level_d = level_q;
        accept  = '0;
        for (int i = 0; i < int'(NB_BTN); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i]  = 1'b1;
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + NB_CNT'(1);
                end
            end
        end
    end

    // Only 0->1 accepts are presses.
    // Isolate the lowest set bit so the pulse is one-hot or zero.
    assign rise    = accept & sync2_q;
    assign pulse_d = rise & (~rise + NB_BTN'(1));

    // Register counters, level and pulse; reset discards any count in progress.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NB_BTN); i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < int'(NB_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_btn_level = level_q;
    assign o_btn_pulse = pulse_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse with short debounce settings.
// A window-based reference model runs next to the design: a level flips when
// the last DB_COUNT synchronised samples all disagree with it. The bench
// compares that model to the design on every cycle. Directed scenarios add
// literal expectations at known edges.
module tb_btn_debounce_pulse;
    localparam int NB_BTN   = 3;
    localparam int NB_CNT   = 4;
    localparam int DB_COUNT = 4;

    logic              clock   = 1'b0;
    logic              i_reset = 1'b1;
    logic [NB_BTN-1:0] i_btn   = '0;
    logic [NB_BTN-1:0] o_btn_level;
    logic [NB_BTN-1:0] o_btn_pulse;

    int checks = 0;
    int errors = 0;

    btn_debounce_pulse #(
        .NB_BTN  (NB_BTN),
        .NB_CNT  (NB_CNT),
        .DB_COUNT(DB_COUNT)
    ) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_btn      (i_btn),
        .o_btn_level(o_btn_level),
        .o_btn_pulse(o_btn_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [NB_BTN-1:0] act, input logic [NB_BTN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Reference model: delay line for the synchroniser, sliding window of samples
    logic [NB_BTN-1:0] m_sync1, m_s, s_now, rise;
    logic [NB_BTN-1:0] win [DB_COUNT];
    logic [NB_BTN-1:0] exp_level = '0;
    logic [NB_BTN-1:0] exp_pulse = '0;
    bit                model_valid = 1'b0;
    bit                stable, found;

    always @(posedge clock) begin
        if (i_reset) begin
            m_sync1 = '0;
            m_s     = '0;
            for (int j = 0; j < DB_COUNT; j++) win[j] = '0;
            exp_level   = '0;
            exp_pulse   = '0;
            model_valid = 1'b1;
        end else begin
            s_now   = m_s;
            m_s     = m_sync1;
            m_sync1 = i_btn;
            for (int j = DB_COUNT - 1; j > 0; j--) win[j] = win[j-1];
            win[0] = s_now;
            rise = '0;
            for (int i = 0; i < NB_BTN; i++) begin
                stable = 1'b1;
                for (int j = 0; j < DB_COUNT; j++)
                    if (win[j][i] == exp_level[i]) stable = 1'b0;
                if (stable) begin
                    exp_level[i] = s_now[i];
                    if (s_now[i]) rise[i] = 1'b1;
                end
            end
            exp_pulse = '0;
            found = 1'b0;
            for (int i = 0; i < NB_BTN; i++) begin
                if (rise[i] && !found) begin
                    exp_pulse[i] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (model_valid) begin
            chk("model_level", o_btn_level, exp_level);
            chk("model_pulse", o_btn_pulse, exp_pulse);
            checks++;
            if (!$onehot0(o_btn_pulse)) begin
                errors++;
                $display("FAIL pulse_onehot: got %b required one-hot or zero at %0t", o_btn_pulse, $time);
            end
        end
    end

    int pcount;
    int hi_count;
    int bounce [6] = '{1, 0, 1, 1, 0, 1};

    initial begin
        i_reset = 1'b1;
        i_btn   = '0;
        repeat (3) step();
        i_reset = 1'b0;
        repeat (4) step();
        chk("reset_level", o_btn_level, 3'b000);
        chk("reset_pulse", o_btn_pulse, 3'b000);

        // clean press
        i_btn = 3'b001;
        repeat (5) step();
        chk("t1_level_pre", o_btn_level, 3'b000);
        step();
        chk("t1_level", o_btn_level, 3'b001);
        chk("t1_pulse", o_btn_pulse, 3'b001);
        step();
        chk("t1_pulse_off", o_btn_pulse, 3'b000);
        chk("t1_level_hold", o_btn_level, 3'b001);
        repeat (5) step();

        // release
        i_btn  = 3'b000;
        pcount = 0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (o_btn_pulse != 3'b000) pcount++;
            if (n == 5) chk("t4_level_pre", o_btn_level, 3'b001);
            if (n == 6) chk("t4_level", o_btn_level, 3'b000);
        end
        chk_int("t4_no_pulse", pcount, 0);

        // glitch of three cycles
        for (int k = 0; k < 12; k++) begin
            i_btn = (k < 3) ? 3'b010 : 3'b000;
            step();
            chk("t2_level", o_btn_level, 3'b000);
            chk("t2_pulse", o_btn_pulse, 3'b000);
        end

        // bounce then steady press
        pcount = 0;
        for (int k = 0; k < 6; k++) begin
            i_btn = (bounce[k] != 0) ? 3'b100 : 3'b000;
            if (k < 5) begin
                step();
                if (o_btn_pulse != 3'b000) pcount++;
            end
        end
        for (int n = 1; n <= 10; n++) begin
            step();
            if (o_btn_pulse != 3'b000) pcount++;
            if (n == 5) chk("t3_level_pre", o_btn_level, 3'b000);
            if (n == 6) begin
                chk("t3_level", o_btn_level, 3'b100);
                chk("t3_pulse", o_btn_pulse, 3'b100);
            end
        end
        chk_int("t3_pulse_count", pcount, 1);
        i_btn = 3'b000;
        repeat (8) step();

        // simultaneous press, lowest index wins
        i_btn    = 3'b101;
        hi_count = 0;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (o_btn_pulse[2]) hi_count++;
            if (n == 6) begin
                chk("t5_level", o_btn_level, 3'b101);
                chk("t5_pulse", o_btn_pulse, 3'b001);
            end
            if (n == 7) chk("t5_pulse_off", o_btn_pulse, 3'b000);
        end
        chk_int("t5_no_pulse_bit2", hi_count, 0);
        i_btn = 3'b000;
        repeat (8) step();

        // reset mid-count
        i_btn = 3'b010;
        repeat (2) step();
        i_reset = 1'b1;
        step();
        chk("t6_rst_level", o_btn_level, 3'b000);
        chk("t6_rst_pulse", o_btn_pulse, 3'b000);
        step();
        chk("t6_rst_level2", o_btn_level, 3'b000);
        i_reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 5) chk("t6_level_pre", o_btn_level, 3'b000);
            if (n == 6) begin
                chk("t6_level", o_btn_level, 3'b010);
                chk("t6_pulse", o_btn_pulse, 3'b010);
            end
            if (n == 7) chk("t6_pulse_off", o_btn_pulse, 3'b000);
        end
        i_btn = 3'b000;
        repeat (8) step();

        // reset while a level is high; a held button becomes a new press
        i_btn = 3'b001;
        repeat (7) step();
        chk("t7_level_before", o_btn_level, 3'b001);
        i_reset = 1'b1;
        step();
        chk("t7_rst_level", o_btn_level, 3'b000);
        chk("t7_rst_pulse", o_btn_pulse, 3'b000);
        i_reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 6) begin
                chk("t7_level", o_btn_level, 3'b001);
                chk("t7_pulse", o_btn_pulse, 3'b001);
            end
        end
        i_btn = 3'b000;
        repeat (8) step();

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) i_btn = NB_BTN'($urandom_range(0, 7));
            i_reset = ($urandom_range(0, 299) == 0);
            step();
        end
        i_reset = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
